// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding,
//   default operand width and the bit-counter width helper.
//   No ports; imported by serial_add.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused; the FSM sends it back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_full_add.sv
// full_add
//   Purely combinational one-bit full adder made of two half-adder stages
//   and an OR on the two partial carries. Used as the serial slice.
//   Ports:
//     a, b  : operand bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_ab;
  logic g_ab;
  logic g_pc;

  // first half adder: a + b
  assign p_ab = a ^ b;
  assign g_ab = a & b;

  // second half adder: (a ^ b) + ci
  assign s    = p_ab ^ ci;
  assign g_pc = p_ab & ci;

  // the two partial carries can never both be 1, so OR is exact
  assign co   = g_ab | g_pc;

endmodule

// File: rtl/serial_add.sv
// serial_add
//   Bit-serial adder: {cy, s} = a + b + cin, one bit per clock, LSB first.
//   A single full_add slice plus a registered carry does the arithmetic.
//   Results are held stable between operations.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : request, honoured in IDLE or DONE
//     a, b   : WIDTH-bit operands, captured on the accepting edge
//     cin    : carry in, captured on the accepting edge
//     busy   : high while bits are being processed
//     done   : one-cycle pulse when s/cy/ov hold a new result
//     s      : registered sum
//     cy     : registered carry out of the MSB
//     ov     : registered two's-complement overflow
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | one operand bit per edge through the slice
//   DONE    | result just committed; start here chains the next op
module serial_add
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cy,
  output logic             ov
);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             sum_bit;
  logic             co;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  full_add u_slice (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (co)
  );

  // Sum bits enter at the MSB, so after WIDTH shifts bit 0 is the LSB.
  assign sr_next  = {sum_bit, sr[WIDTH-1:1]};
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cy    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            carry <= cin;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // start is deliberately ignored here
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          carry <= co;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            s     <= sr_next;
            cy    <= co;
            // carry into the MSB slice is the registered carry right now
            ov    <= carry ^ co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add.sv
module tb_serial_add;

  logic        clk;
  logic        rst_n;

  logic        start8, cin8, busy8, done8, cy8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        start13, cin13, busy13, done13, cy13, ov13;
  logic [12:0] a13, b13, s13;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] last_s  [2];
  logic        last_cy [2];
  logic        last_ov [2];

  serial_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cy(cy8), .ov(ov8)
  );

  serial_add #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .s(s13), .cy(cy13), .ov(ov13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx(input int w);
    return (w == 13) ? 1 : 0;
  endfunction

  function automatic logic [63:0] obs_s(input int w);
    return (w == 13) ? 64'(s13) : 64'(s8);
  endfunction
  function automatic logic obs_busy(input int w);
    return (w == 13) ? busy13 : busy8;
  endfunction
  function automatic logic obs_done(input int w);
    return (w == 13) ? done13 : done8;
  endfunction
  function automatic logic obs_cy(input int w);
    return (w == 13) ? cy13 : cy8;
  endfunction
  function automatic logic obs_ov(input int w);
    return (w == 13) ? ov13 : ov8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition modulo 2^w; overflow from operand signs.
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, output logic [63:0] es, output logic ecy,
                       output logic eov);
    logic [63:0] mask, am, bm;
    logic [64:0] sum;
    mask = (64'd1 << w) - 64'd1;
    am   = av & mask;
    bm   = bv & mask;
    sum  = {1'b0, am} + {1'b0, bm} + 65'(ci);
    es   = sum[63:0] & mask;
    ecy  = sum[w];
    eov  = (am[w-1] == bm[w-1]) && (es[w-1] != am[w-1]);
  endtask

  task automatic drive(input int w, input logic st, input logic [63:0] av,
                       input logic [63:0] bv, input logic ci);
    if (w == 13) begin
      start13 = st; a13 = av[12:0]; b13 = bv[12:0]; cin13 = ci;
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci;
    end
  endtask

  // Called at a negedge; returns at the next negedge with start released.
  task automatic issue(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci);
    drive(w, 1'b1, av, bv, ci);
    @(negedge clk);
    drive(w, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  // Counts busy negedges until done, checking outputs hold the old result.
  task automatic wait_done(input int w, output int nb);
    nb = 0;
    while (!obs_done(w) && nb < 200) begin
      chk("busy_in_run", 64'(obs_busy(w)), 64'd1);
      chk("s_hold", obs_s(w), last_s[idx(w)]);
      chk("cy_hold", 64'(obs_cy(w)), 64'(last_cy[idx(w)]));
      nb++;
      @(negedge clk);
    end
    chk("done_seen", 64'(obs_done(w)), 64'd1);
    chk("busy_at_done", 64'(obs_busy(w)), 64'd0);
  endtask

  task automatic check_result(input int w, input logic [63:0] av, input logic [63:0] bv,
                              input logic ci);
    logic [63:0] es;
    logic        ecy, eov;
    model(w, av, bv, ci, es, ecy, eov);
    chk("s", obs_s(w), es);
    chk("cy", 64'(obs_cy(w)), 64'(ecy));
    chk("ov", 64'(obs_ov(w)), 64'(eov));
    last_s[idx(w)]  = es;
    last_cy[idx(w)] = ecy;
    last_ov[idx(w)] = eov;
  endtask

  task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci);
    int nb;
    @(negedge clk);
    issue(w, av, bv, ci);
    wait_done(w, nb);
    chk("busy_cycles", 64'(nb), 64'(w));
    check_result(w, av, bv, ci);
    @(negedge clk);
    chk("done_single", 64'(obs_done(w)), 64'd0);
  endtask

  initial begin
    int nb;
    logic [63:0] ra, rb;
    logic rc;

    for (int i = 0; i < 2; i++) begin
      last_s[i] = '0; last_cy[i] = 1'b0; last_ov[i] = 1'b0;
    end
    rst_n = 1'b0;
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(13, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_s8", 64'(s8), 64'd0);
    chk("rst_s13", 64'(s13), 64'd0);
    rst_n = 1'b1;

    // directed operations
    run_op(8, 64'h5A, 64'h33, 1'b0);
    run_op(8, 64'hFF, 64'h01, 1'b0);
    run_op(8, 64'h7F, 64'h00, 1'b1);

    // start pulsed mid-RUN is ignored
    @(negedge clk);
    issue(8, 64'h5A, 64'h33, 1'b0);
    repeat (2) @(negedge clk);
    drive(8, 1'b1, 64'h10, 64'h10, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
    wait_done(8, nb);
    chk("glitch_busy_left", 64'(nb), 64'd5);
    check_result(8, 64'h5A, 64'h33, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("glitch_no_done", 64'(done8), 64'd0);
      chk("glitch_no_busy", 64'(busy8), 64'd0);
    end

    // back-to-back: start in the DONE cycle
    @(negedge clk);
    issue(8, 64'hFF, 64'h01, 1'b0);
    wait_done(8, nb);
    check_result(8, 64'hFF, 64'h01, 1'b0);
    issue(8, 64'h01, 64'h02, 1'b0);
    wait_done(8, nb);
    chk("b2b_done_gap", 64'(nb + 1), 64'd9);
    check_result(8, 64'h01, 64'h02, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    issue(8, 64'hA5, 64'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_s", 64'(s8), 64'd0);
    chk("arst_cy", 64'(cy8), 64'd0);
    chk("arst_ov", 64'(ov8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      last_s[i] = '0; last_cy[i] = 1'b0; last_ov[i] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(busy8), 64'd0);
    end
    run_op(8, 64'h80, 64'h80, 1'b0);

    // random sweep on both widths
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
        run_op((w == 0) ? 8 : 13, ra, rb, rc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
